// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the restoring-division controller.
package div_ctrl_pkg;

    localparam int unsigned ITER  = 5;
    localparam int unsigned CNT_W = 3;

    localparam logic OP_SUB = 1'b1;
    localparam logic OP_ADD = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OVF_SUB,
        OVF_TEST,
        SHIFT,
        SUB,
        TEST,
        DONE
    } state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the shift/subtract loop; tc flags the final iteration.
module div_iter_counter #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned ITER  = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(ITER - 1));

endmodule

// File: rtl/divider_controller.sv
// Sequencer for the 10/5-bit restoring-division datapath: operand load,
// overflow pre-check, then ITER shift/subtract/test iterations.
module divider_controller
    import div_ctrl_pkg::*;
#(
    parameter int unsigned ITER_N  = ITER,
    parameter int unsigned CNT_N_W = CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sign,
    output logic ready,
    output logic done,
    output logic overflow,
    output logic ld_d,
    output logic ld_x,
    output logic sel_x,
    output logic shift_x,
    output logic count_up_x,
    output logic ld_q,
    output logic shift_q,
    output logic count_up_q,
    output logic ld_e,
    output logic op_sel,
    output logic add_or_sub
);

    state_t state;
    state_t state_next;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   last_iter;

    div_iter_counter #(
        .CNT_W (CNT_N_W),
        .ITER  (ITER_N)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (last_iter)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = LOAD;
            LOAD:     state_next = OVF_SUB;
            OVF_SUB:  state_next = OVF_TEST;
            OVF_TEST: state_next = sign ? SHIFT : DONE;
            SHIFT:    state_next = SUB;
            SUB:      state_next = TEST;
            TEST:     state_next = last_iter ? DONE : SHIFT;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Control decode; sign=0 after a subtract means X >= D.
    always_comb begin
        ready      = 1'b0;
        done       = 1'b0;
        ld_d       = 1'b0;
        ld_x       = 1'b0;
        sel_x      = 1'b0;
        shift_x    = 1'b0;
        count_up_x = 1'b0;
        ld_q       = 1'b0;
        shift_q    = 1'b0;
        count_up_q = 1'b0;
        ld_e       = 1'b0;
        op_sel     = OP_ADD;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            LOAD: begin
                ld_d = 1'b1;
                ld_x = 1'b1;
                ld_q = 1'b1;
            end
            OVF_SUB: begin
                ld_x   = 1'b1;
                sel_x  = 1'b1;
                op_sel = OP_SUB;
            end
            OVF_TEST: begin
                cnt_clear = 1'b1;
                if (sign) begin
                    ld_x   = 1'b1;
                    sel_x  = 1'b1;
                    op_sel = OP_ADD;
                end
            end
            SHIFT: begin
                shift_x = 1'b1;
                shift_q = 1'b1;
            end
            SUB: begin
                ld_x   = 1'b1;
                sel_x  = 1'b1;
                op_sel = OP_SUB;
                ld_e   = 1'b1;
            end
            TEST: begin
                cnt_inc = !last_iter;
                if (sign) begin
                    ld_x   = 1'b1;
                    sel_x  = 1'b1;
                    op_sel = OP_ADD;
                end else begin
                    count_up_q = 1'b1;
                end
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign add_or_sub = op_sel;

    // Sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            overflow <= 1'b0;
        end else if (state == OVF_TEST && !sign) begin
            overflow <= 1'b1;
        end
    end

endmodule
